// File: rtl/sec_clk_pkg.sv
// Shared timebase constants and divider helper for the seconds/minute/hour stages.
package sec_clk_pkg;

  localparam int REF_FREQ_HZ = 65536;
  localparam int SEC_FREQ_HZ = 1;

  // Reference edges per output half-period; 0 flags an unusable output frequency.
  function automatic int calc_half_div(input int in_hz, input int out_hz);
    if (out_hz < 1) return 0;
    return in_hz / (2 * out_hz);
  endfunction

endpackage

// File: rtl/clk_div_counter.sv
// Free-running modulo-(MAX+1) counter; wrap flags the terminal count of the registered value.
module clk_div_counter
  import sec_clk_pkg::*;
#(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic clk,
  input  logic rst,
  output logic wrap
);

  localparam logic [W-1:0] TERM = W'(MAX);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (count == TERM) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign wrap = (count == TERM);

endmodule

// File: rtl/sec_clk.sv
// Divides the reference clock to a 50%-duty output clock (1 Hz by default).
// Define SEC_CLK_TICK_EN to add the tick port: a one-cycle pulse on each rising clk_out.
module sec_clk
  import sec_clk_pkg::*;
#(
  parameter int IN_FREQ_HZ  = REF_FREQ_HZ,
  parameter int OUT_FREQ_HZ = SEC_FREQ_HZ
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_out
`ifdef SEC_CLK_TICK_EN
  ,
  output logic tick
`endif
);

  localparam int HALF_DIV = calc_half_div(IN_FREQ_HZ, OUT_FREQ_HZ);
  localparam int CNT_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int OUT_SAFE = (OUT_FREQ_HZ < 1) ? 1 : OUT_FREQ_HZ;

  generate
    if (OUT_FREQ_HZ < 1 || (IN_FREQ_HZ % (2 * OUT_SAFE)) != 0 || HALF_DIV < 1) begin : g_bad_params
      $error("sec_clk: IN_FREQ_HZ must be a positive multiple of 2*OUT_FREQ_HZ");
    end
  endgenerate

  logic wrap;

  clk_div_counter #(
    .MAX (HALF_DIV - 1),
    .W   (CNT_W)
  ) u_div (
    .clk  (clk_in),
    .rst  (rst),
    .wrap (wrap)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      clk_out <= 1'b0;
    end else if (wrap) begin
      clk_out <= ~clk_out;
    end
  end

`ifdef SEC_CLK_TICK_EN
  // Fires on the same edge that drives clk_out 0->1, so consumers can stay on clk_in.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= wrap & ~clk_out;
    end
  end
`endif

endmodule

// File: tb/tb_sec_clk.sv
// Bench for sec_clk: default 1 Hz divider plus HALF_DIV=4 and HALF_DIV=1 overrides.
module tb_sec_clk;

  typedef struct {
    int   edge_n;
    logic val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_def, rst_8, rst_2;
  logic out_def, out_8, out_2;
  logic tick_def, tick_8, tick_2;

  int checks = 0;
  int errors = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  exp_tick_q[$];
  int  obs_tick_q[$];

  always #5 clk = ~clk;

  sec_clk dut_def (
    .clk_in  (clk),
    .rst     (rst_def),
    .clk_out (out_def)
`ifdef SEC_CLK_TICK_EN
    ,
    .tick    (tick_def)
`endif
  );

  sec_clk #(.IN_FREQ_HZ(8), .OUT_FREQ_HZ(1)) dut_8 (
    .clk_in  (clk),
    .rst     (rst_8),
    .clk_out (out_8)
`ifdef SEC_CLK_TICK_EN
    ,
    .tick    (tick_8)
`endif
  );

  sec_clk #(.IN_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut_2 (
    .clk_in  (clk),
    .rst     (rst_2),
    .clk_out (out_2)
`ifdef SEC_CLK_TICK_EN
    ,
    .tick    (tick_2)
`endif
  );

`ifndef SEC_CLK_TICK_EN
  assign tick_def = 1'b0;
  assign tick_8   = 1'b0;
  assign tick_2   = 1'b0;
`endif

  function automatic logic out_of(input int which);
    case (which)
      0:       return out_def;
      1:       return out_8;
      default: return out_2;
    endcase
  endfunction

  function automatic logic tick_of(input int which);
    case (which)
      0:       return tick_def;
      1:       return tick_8;
      default: return tick_2;
    endcase
  endfunction

  // Records clk_out toggles and tick pulses by rising-edge number (1 = first edge after call).
  task automatic observe(input int which, input int n_edges);
    logic prev, cur;
    prev = out_of(which);
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      #1;
      cur = out_of(which);
      if (cur !== prev) obs_q.push_back('{e, cur});
      prev = cur;
      if (tick_of(which) === 1'b1) obs_tick_q.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst_def = 1'b1;
    rst_8   = 1'b1;
    rst_2   = 1'b1;
    #2;
    // No clock edge yet: only the asynchronous reset can have cleared the outputs.
    checks++;
    if (out_def !== 1'b0) begin errors++; $display("FAIL reset_async_def: got %b, expected 0", out_def); end
    #23;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_def !== 1'b0) begin errors++; $display("FAIL reset_hold_def: got %b, expected 0", out_def); end
    checks++;
    if (out_8 !== 1'b0) begin errors++; $display("FAIL reset_hold_8: got %b, expected 0", out_8); end
    checks++;
    if (out_2 !== 1'b0) begin errors++; $display("FAIL reset_hold_2: got %b, expected 0", out_2); end
`ifdef SEC_CLK_TICK_EN
    checks++;
    if (tick_def !== 1'b0) begin errors++; $display("FAIL reset_tick_def: got %b, expected 0", tick_def); end
    checks++;
    if (tick_8 !== 1'b0) begin errors++; $display("FAIL reset_tick_8: got %b, expected 0", tick_8); end
`endif
  endtask

  task automatic test_div4;
    ev_t e, o;
    int  te, to;
    obs_q.delete();
    obs_tick_q.delete();
    for (int k = 1; k <= 6; k++) exp_q.push_back('{4 * k, logic'(k % 2)});
    exp_tick_q.push_back(4);
    exp_tick_q.push_back(12);
    exp_tick_q.push_back(20);
    @(negedge clk);
    rst_8 = 1'b0;
    observe(1, 26);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL div4_toggle_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.edge_n !== e.edge_n || o.val !== e.val) begin
        errors++;
        $display("FAIL div4_toggle: got edge %0d val %b, expected edge %0d val %b", o.edge_n, o.val, e.edge_n, e.val);
      end
    end
`ifdef SEC_CLK_TICK_EN
    checks++;
    if (obs_tick_q.size() != exp_tick_q.size()) begin
      errors++; $display("FAIL div4_tick_count: got %0d, expected %0d", obs_tick_q.size(), exp_tick_q.size());
    end
    while (exp_tick_q.size() > 0 && obs_tick_q.size() > 0) begin
      te = exp_tick_q.pop_front();
      to = obs_tick_q.pop_front();
      checks++;
      if (to !== te) begin errors++; $display("FAIL div4_tick_edge: got %0d, expected %0d", to, te); end
    end
`endif
    exp_q.delete();
    obs_q.delete();
    exp_tick_q.delete();
    obs_tick_q.delete();
  endtask

  task automatic test_div2;
    ev_t e, o;
    obs_q.delete();
    for (int k = 1; k <= 8; k++) exp_q.push_back('{k, logic'(k % 2)});
    @(negedge clk);
    rst_2 = 1'b0;
    observe(2, 8);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL div1_toggle_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.edge_n !== e.edge_n || o.val !== e.val) begin
        errors++;
        $display("FAIL div1_toggle: got edge %0d val %b, expected edge %0d val %b", o.edge_n, o.val, e.edge_n, e.val);
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_async_reset;
    ev_t e, o;
    @(negedge clk);
    rst_8 = 1'b1;
    @(negedge clk);
    rst_8 = 1'b0;
    observe(1, 5);
    checks++;
    if (out_8 !== 1'b1) begin errors++; $display("FAIL midreset_precond: got %b, expected 1", out_8); end
    // Now 1 ns past an edge; assert reset 3 ns after it, well before the next edge.
    #2;
    rst_8 = 1'b1;
    #1;
    checks++;
    if (out_8 !== 1'b0) begin errors++; $display("FAIL midreset_immediate: got %b, expected 0", out_8); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_8 !== 1'b0) begin errors++; $display("FAIL midreset_hold: got %b, expected 0", out_8); end
    end
    obs_q.delete();
    obs_tick_q.delete();
    exp_q.push_back('{4, 1'b1});
    exp_q.push_back('{8, 1'b0});
    @(negedge clk);
    rst_8 = 1'b0;
    observe(1, 9);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL midreset_toggle_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.edge_n !== e.edge_n || o.val !== e.val) begin
        errors++;
        $display("FAIL midreset_toggle: got edge %0d val %b, expected edge %0d val %b", o.edge_n, o.val, e.edge_n, e.val);
      end
    end
    exp_q.delete();
    obs_q.delete();
    obs_tick_q.delete();
  endtask

  task automatic test_default_period;
    ev_t e, o;
    int  te, to;
    obs_q.delete();
    obs_tick_q.delete();
    exp_q.push_back('{32768, 1'b1});
    exp_q.push_back('{65536, 1'b0});
    exp_tick_q.push_back(32768);
    @(negedge clk);
    rst_def = 1'b0;
    observe(0, 65540);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL def_toggle_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o.edge_n !== e.edge_n || o.val !== e.val) begin
        errors++;
        $display("FAIL def_toggle: got edge %0d val %b, expected edge %0d val %b", o.edge_n, o.val, e.edge_n, e.val);
      end
    end
`ifdef SEC_CLK_TICK_EN
    checks++;
    if (obs_tick_q.size() != exp_tick_q.size()) begin
      errors++; $display("FAIL def_tick_count: got %0d, expected %0d", obs_tick_q.size(), exp_tick_q.size());
    end
    while (exp_tick_q.size() > 0 && obs_tick_q.size() > 0) begin
      te = exp_tick_q.pop_front();
      to = obs_tick_q.pop_front();
      checks++;
      if (to !== te) begin errors++; $display("FAIL def_tick_edge: got %0d, expected %0d", to, te); end
    end
`endif
    exp_q.delete();
    obs_q.delete();
    exp_tick_q.delete();
    obs_tick_q.delete();
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div2();
    test_async_reset();
    test_default_period();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
